pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline register for the inter-stage latches of the multi-core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data field and a separately handled control field through one stage using a valid/ready handshake instead of a bare enable. Flush forces a bubble, and an optional two-entry skid buffer breaks the combinational ready path between stages. Hazard and forwarding units drive `flush` and observe `count`.

---
 rtl/cpu_types_pkg.sv | 75 +++++++
 rtl/pipe_stage_buf.sv | 132 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: inter-stage latch state encoding and the per-stage
// field layouts that callers pack into pipe_stage_buf's data/control buses.
package cpu_types_pkg;

  localparam int unsigned PIPE_CNT_W = 2;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 4;

  // Control bits shared by every stage; the later stages simply ignore the
  // fields they no longer need.
  typedef struct packed {
    logic               reg_wr;
    logic               d_wen;
    logic               d_ren;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_to_reg;
    logic               branch;
    logic               jump;
    logic               link;
    logic               lui;
    logic               halt;
    logic [1:0]         rsvd;
  } stage_ctrl_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] rsvd0;
    logic [WORD_W-1:0] rsvd1;
  } if_id_data_t;

  typedef struct packed {
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] rs_val;
    logic [WORD_W-1:0] rt_val;
    logic [WORD_W-1:0] imm;
  } id_ex_data_t;

  typedef struct packed {
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] store_val;
    logic [REG_W-1:0]  wsel;
    logic [WORD_W-REG_W-1:0] rsvd;
  } ex_mem_data_t;

  typedef struct packed {
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] load_val;
    logic [REG_W-1:0]  wsel;
    logic [WORD_W-REG_W-1:0] rsvd;
  } mem_wb_data_t;

  function automatic logic [PIPE_CNT_W-1:0] pipe_count(input pipe_state_t st);
    logic [PIPE_CNT_W-1:0] cnt;
    cnt = '0;
    case (st)
      PS_ONE:  cnt = 2'd1;
      PS_FULL: cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build with registered in_ready.
module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTRL_W-1:0]     out_ctrl,
  input  logic                  flush,
  output logic [PIPE_CNT_W-1:0] count
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              in_xfer;
  logic              out_xfer;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = ~out_valid | out_ready;
`endif

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign count     = pipe_count(state_q);

  assign in_xfer  = in_valid & in_ready & ~flush;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif

    case (state_q)
      PS_EMPTY: begin
        if (in_xfer) begin
          state_d     = PS_ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      PS_ONE: begin
        if (in_xfer && out_xfer) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
        end else if (in_xfer) begin
          state_d     = PS_FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
`endif
        end else if (out_xfer) begin
          state_d     = PS_EMPTY;
          main_ctrl_d = CTRL_BUBBLE;
        end
      end
      PS_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
        // in_ready is low here, so only a drain can happen.
        if (out_xfer) begin
          state_d     = PS_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
`else
        state_d     = PS_EMPTY;
        main_ctrl_d = CTRL_BUBBLE;
`endif
      end
      default: begin
        state_d     = PS_EMPTY;
        main_ctrl_d = CTRL_BUBBLE;
      end
    endcase

    // Flush wins over every transfer; a coincident drain is still taken downstream.
    if (flush) begin
      state_d     = PS_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
    end

`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != PS_FULL);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= PS_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: scoreboard monitor for ordering plus
// cycle-exact checks of count, in_ready and bubble behaviour.
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CTRL_W = 16;
  localparam logic [CTRL_W-1:0] BUB = 16'hB0B0;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [1:0]        count;

  int n_cmp  = 0;
  int n_fail = 0;
  ent_t sb_q[$];

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUB)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DATA_W-1:0] mk(input logic [CTRL_W-1:0] c);
    return {8{c ^ 16'h5A00}};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = mk(c);
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic check_empty(input string name);
    check({name, ".out_valid"}, DATA_W'(out_valid), DATA_W'(1'b0));
    check({name, ".out_ctrl"}, DATA_W'(out_ctrl), DATA_W'(BUB));
    check({name, ".count"}, DATA_W'(count), DATA_W'(2'd0));
  endtask

  // Scoreboard: drain side pops first, then flush/accept updates the queue.
  always @(negedge CLK) begin
    ent_t e;
    if (RST) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got ctrl %0h expected no transfer", out_ctrl);
        end else begin
          e = sb_q.pop_front();
          if (out_ctrl !== e.c || out_data !== e.d) begin
            n_fail++;
            $display("FAIL sb_order: got ctrl %0h data %0h expected ctrl %0h data %0h",
                     out_ctrl, out_data, e.c, e.d);
          end else
            $display("xfer out ctrl %0h", out_ctrl);
        end
      end
      if (!out_valid) begin
        n_cmp++;
        if (out_ctrl !== BUB) begin
          n_fail++;
          $display("FAIL bubble_ctrl: got %0h expected %0h", out_ctrl, BUB);
        end
      end
      if (flush)
        sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back('{c: in_ctrl, d: in_data});
    end
  end

  initial begin
    RST = 1'b1; in_valid = 1'b1; in_ctrl = 16'h00AA; in_data = mk(16'h00AA);
    out_ready = 1'b1; flush = 1'b0;

    // Reset with in_valid held high
    step(); step();
    check_empty("reset");
    check("reset.in_ready", DATA_W'(in_ready), DATA_W'(1'b1));
    check("reset.out_data", out_data, '0);
    RST = 1'b0; in_valid = 1'b0;
    step();
    check_empty("post_reset");

    // Streaming with out_ready held high
    drive(16'h0001); step();
    check("stream1.ctrl", DATA_W'(out_ctrl), DATA_W'(16'h0001));
    check("stream1.count", DATA_W'(count), DATA_W'(2'd1));
    drive(16'h0002); step();
    check("stream2.ctrl", DATA_W'(out_ctrl), DATA_W'(16'h0002));
    check("stream2.count", DATA_W'(count), DATA_W'(2'd1));
    drive(16'h0003); step();
    check("stream3.ctrl", DATA_W'(out_ctrl), DATA_W'(16'h0003));
    check("stream3.data", out_data, mk(16'h0003));
    check("stream3.count", DATA_W'(count), DATA_W'(2'd1));
    in_valid = 1'b0; step();
    check_empty("stream_drain");

    // Backpressure
    out_ready = 1'b0;
    drive(16'h0021); step();
    check("bp.first", DATA_W'(out_ctrl), DATA_W'(16'h0021));
    check("bp.count1", DATA_W'(count), DATA_W'(2'd1));
`ifdef PIPE_STAGE_SKID_EN
    check("bp.in_ready1", DATA_W'(in_ready), DATA_W'(1'b1));
    drive(16'h0022); step();
    check("bp.count2", DATA_W'(count), DATA_W'(2'd2));
    check("bp.in_ready_full", DATA_W'(in_ready), DATA_W'(1'b0));
    check("bp.head_a", DATA_W'(out_ctrl), DATA_W'(16'h0021));
    drive(16'h0023); step();
    check("bp.held_count", DATA_W'(count), DATA_W'(2'd2));
    check("bp.held_head", DATA_W'(out_ctrl), DATA_W'(16'h0021));
    out_ready = 1'b1; step();
    check("bp.drain_b", DATA_W'(out_ctrl), DATA_W'(16'h0022));
    check("bp.drain_count", DATA_W'(count), DATA_W'(2'd1));
    check("bp.in_ready_back", DATA_W'(in_ready), DATA_W'(1'b1));
    step();
    check("bp.c_late", DATA_W'(out_ctrl), DATA_W'(16'h0023));
    check("bp.c_count", DATA_W'(count), DATA_W'(2'd1));
`else
    check("bp.in_ready_comb_lo", DATA_W'(in_ready), DATA_W'(1'b0));
    drive(16'h0022); step();
    check("bp.held_head", DATA_W'(out_ctrl), DATA_W'(16'h0021));
    check("bp.count_max1", DATA_W'(count), DATA_W'(2'd1));
    out_ready = 1'b1; #1;
    check("bp.in_ready_comb_hi", DATA_W'(in_ready), DATA_W'(1'b1));
    step();
    check("bp.replace", DATA_W'(out_ctrl), DATA_W'(16'h0022));
    check("bp.replace_count", DATA_W'(count), DATA_W'(2'd1));
`endif
    in_valid = 1'b0; step();
    check_empty("bp_drain");

    // Flush with one held entry, a drain and an offered input at the same edge
    out_ready = 1'b0;
    drive(16'h0031); step();
`ifdef PIPE_STAGE_SKID_EN
    drive(16'h0032); step();
    check("flush.full_count", DATA_W'(count), DATA_W'(2'd2));
    drive(16'h0033);
`else
    out_ready = 1'b1;
    drive(16'h0032);
`endif
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush");
    check("flush.in_ready", DATA_W'(in_ready), DATA_W'(1'b1));
    check("flush.data_hold", out_data, mk(16'h0031));
    step();
    check_empty("flush_after");

    // Reset coincident with flush and a drain while holding entries
    out_ready = 1'b0;
    drive(16'h0041); step();
`ifdef PIPE_STAGE_SKID_EN
    drive(16'h0042); step();
    check("rst_mid.count_pre", DATA_W'(count), DATA_W'(2'd2));
`else
    check("rst_mid.count_pre", DATA_W'(count), DATA_W'(2'd1));
`endif
    RST = 1'b1; flush = 1'b1; out_ready = 1'b1; drive(16'h0043);
    step();
    check_empty("rst_mid");
    check("rst_mid.in_ready", DATA_W'(in_ready), DATA_W'(1'b1));
    check("rst_mid.out_data", out_data, '0);
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step(); step();
    check_empty("rst_mid_after");

    check("sb_leftover", DATA_W'(sb_q.size()), DATA_W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
